hydra_wdt_lockstep: RTL

Parametrised multi-channel lockstep watchdog for the Hydra SoC, the successor to the single-channel `wdt0`. Each of `N_CH` redundant cores posts a heartbeat value. The block checks three things:
- every channel kicks within a timeout window;
- all channels kick within a bounded skew of each other;
- all heartbeat values match.

Any violation raises a sticky, classified fault. The fault drives the SoC fault/recovery logic and is visible to the testbench for fault-injection runs.

---
 rtl/hydra_wdt_lockstep.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/hydra_wdt_lockstep.sv
// Multi-channel lockstep watchdog: per-round timeout, inter-channel kick skew
// and heartbeat equality checks, with a sticky classified fault.
module hydra_wdt_lockstep #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned DW      = 32,
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 5000,
  parameter int unsigned SKEW    = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [N_CH-1:0]      din_val,
  input  logic [N_CH*DW-1:0]   din,
  input  logic                 fault_clr,
  output logic                 fault,
  output logic [1:0]           fault_code,
  output logic [N_CH-1:0]      fault_ch,
  output logic                 ok,
  output logic [CW-1:0]        ok_count,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, ARMED, COLLECT, COMPARE, FAULT} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        tcnt, tcnt_n, scnt, scnt_n, ok_count_n;
  logic [N_CH-1:0]      mask, mask_n, new_mask, dup, diff, fault_ch_n;
  logic [N_CH*DW-1:0]   data, data_n, cap_data;
  logic                 fault_n, ok_n, busy_n;
  logic [1:0]           fault_code_n;

  // Bit 0 of the difference mask flags channel 0 only when it disagrees with every other channel.
  always_comb begin
    logic all_diff;
    logic d;
    diff     = '0;
    all_diff = 1'b1;
    for (int unsigned i = 1; i < N_CH; i++) begin
      d        = data[i*DW +: DW] != data[0 +: DW];
      diff[i]  = d;
      all_diff = all_diff & d;
    end
    diff[0] = all_diff;
  end

  always_comb begin
    cap_data = data;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (din_val[i]) cap_data[i*DW +: DW] = din[i*DW +: DW];
    end
  end

  assign new_mask = mask | din_val;
  assign dup      = mask & din_val;

  always_comb begin
    state_n      = state;
    tcnt_n       = tcnt;
    scnt_n       = scnt;
    mask_n       = mask;
    data_n       = data;
    fault_n      = fault;
    fault_code_n = fault_code;
    fault_ch_n   = fault_ch;
    ok_n         = 1'b0;
    ok_count_n   = ok_count;

    case (state)
      IDLE: begin
        if (en) begin
          state_n = ARMED;
          tcnt_n  = CW'(TIMEOUT);
        end
      end
      ARMED: begin
        if (!en) begin
          state_n = IDLE;
          mask_n  = '0;
        end else if (|din_val) begin
          data_n = cap_data;
          mask_n = new_mask;
          if (&new_mask) begin
            state_n = COMPARE;
          end else begin
            state_n = COLLECT;
            scnt_n  = CW'(SKEW);
          end
        end else if (tcnt == '0) begin
          state_n      = FAULT;
          fault_n      = 1'b1;
          fault_code_n = 2'd1;
          fault_ch_n   = '1;
        end else begin
          tcnt_n = tcnt - CW'(1);
        end
      end
      COLLECT: begin
        if (!en) begin
          state_n = IDLE;
          mask_n  = '0;
        end else if (|dup) begin
          state_n      = FAULT;
          mask_n       = '0;
          fault_n      = 1'b1;
          fault_code_n = 2'd3;
          fault_ch_n   = dup;
        end else if (&new_mask) begin
          state_n = COMPARE;
          data_n  = cap_data;
          mask_n  = new_mask;
        end else if (scnt == '0) begin
          state_n      = FAULT;
          mask_n       = '0;
          fault_n      = 1'b1;
          fault_code_n = 2'd2;
          fault_ch_n   = ~new_mask;
        end else begin
          data_n = cap_data;
          mask_n = new_mask;
          scnt_n = scnt - CW'(1);
        end
      end
      COMPARE: begin
        mask_n = '0;
        if (!en) begin
          state_n = IDLE;
        end else if (|diff) begin
          state_n      = FAULT;
          fault_n      = 1'b1;
          fault_code_n = 2'd3;
          fault_ch_n   = diff;
        end else begin
          state_n    = ARMED;
          tcnt_n     = CW'(TIMEOUT);
          ok_n       = 1'b1;
          ok_count_n = ok_count + CW'(1);
        end
      end
      FAULT: begin
        if (fault_clr) begin
          state_n      = en ? ARMED : IDLE;
          tcnt_n       = CW'(TIMEOUT);
          fault_n      = 1'b0;
          fault_code_n = 2'd0;
          fault_ch_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == COLLECT) || (state_n == COMPARE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      tcnt       <= '0;
      scnt       <= '0;
      mask       <= '0;
      data       <= '0;
      fault      <= 1'b0;
      fault_code <= 2'd0;
      fault_ch   <= '0;
      ok         <= 1'b0;
      ok_count   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      tcnt       <= tcnt_n;
      scnt       <= scnt_n;
      mask       <= mask_n;
      data       <= data_n;
      fault      <= fault_n;
      fault_code <= fault_code_n;
      fault_ch   <= fault_ch_n;
      ok         <= ok_n;
      ok_count   <= ok_count_n;
      busy       <= busy_n;
    end
  end

endmodule
